// File: rtl/nvm_page_program_sequencer.sv
// Streams the 256-byte NVM image from the image RAM to the target, one page at a time:
// each page is erased, then written, with a fixed settle wait after each step.
module nvm_page_program_sequencer #(
    parameter logic [7:0] CTRL_REG    = 8'h10,
    parameter logic [7:0] CTRL_NVM    = 8'h14,
    parameter logic [7:0] ERASE_REG   = 8'hE3,
    parameter logic [7:0] ERASE_CMD   = 8'h80,
    parameter int         NUM_PAGES   = 16,
    parameter int         PAGE_BYTES  = 16,
    parameter int         WAIT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code,
    output logic [3:0] page_idx,
    output logic [7:0] mem_address,
    output logic       mem_clken,
    input  logic [7:0] mem_readdata,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       tx_stop,
    input  logic       tx_done,
    input  logic       tx_nack
);
    localparam int TW = $clog2(WAIT_CYCLES + 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_E_CTRL = 4'd1;
    localparam logic [3:0] S_E_REG  = 4'd2;
    localparam logic [3:0] S_E_DATA = 4'd3;
    localparam logic [3:0] S_E_WAIT = 4'd4;
    localparam logic [3:0] S_W_CTRL = 4'd5;
    localparam logic [3:0] S_W_ADDR = 4'd6;
    localparam logic [3:0] S_FETCH  = 4'd7;
    localparam logic [3:0] S_W_DATA = 4'd8;
    localparam logic [3:0] S_W_WAIT = 4'd9;

    logic [3:0]    state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [3:0]    page_q, page_d;
    logic [7:0]    addr_q, addr_d;
    logic          clken_q, clken_d;
    logic          txv_q, txv_d, txs_q, txs_d, txp_q, txp_d;
    logic [7:0]    txd_q, txd_d;
    logic          sent_q, sent_d, fph_q, fph_d, abrt_q, abrt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    bidx_q, bidx_d;

    logic [7:0] base;
    logic       byte_st, abort_now, last_byte;
    logic [7:0] b_data;
    logic       b_start, b_stop;

    assign base      = 8'({4'b0, page_q} * 8'(PAGE_BYTES));
    assign abort_now = abrt_q | abort;
    assign last_byte = (bidx_q == 8'(PAGE_BYTES - 1));
    assign byte_st   = (state_q == S_E_CTRL) || (state_q == S_E_REG)
                    || (state_q == S_E_DATA) || (state_q == S_W_CTRL)
                    || (state_q == S_W_ADDR) || (state_q == S_W_DATA);

    always_comb begin
        b_data  = txd_q;
        b_start = 1'b0;
        b_stop  = 1'b0;
        case (state_q)
            S_E_CTRL: begin b_data = CTRL_REG; b_start = 1'b1; end
            S_E_REG:  b_data = ERASE_REG;
            S_E_DATA: begin b_data = ERASE_CMD | {4'b0, page_q}; b_stop = 1'b1; end
            S_W_CTRL: begin b_data = CTRL_NVM; b_start = 1'b1; end
            S_W_ADDR: b_data = base;
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q; busy_d = busy_q; done_d = 1'b0;
        err_d   = err_q;   page_d = page_q; addr_d = addr_q;
        clken_d = clken_q; txv_d  = txv_q;  txd_d  = txd_q;
        txs_d   = txs_q;   txp_d  = txp_q;  sent_d = sent_q;
        fph_d   = fph_q;   timer_d = timer_q; bidx_d = bidx_q;
        abrt_d  = abrt_q | (abort & busy_q);

        if (state_q == S_IDLE) begin
            if (start) begin
                err_d = 2'd0; page_d = 4'd0; busy_d = 1'b1;
                abrt_d = 1'b0; state_d = S_E_CTRL;
            end
        end else if (byte_st) begin
            if (!txv_q && !sent_q) begin
                txv_d = 1'b1; txd_d = b_data;
                txs_d = b_start; txp_d = b_stop;
            end else if (txv_q && tx_ready) begin
                txv_d = 1'b0; sent_d = 1'b1;
            end else if (sent_q && tx_done) begin
                sent_d = 1'b0;
                if (tx_nack || abort_now) begin
                    // NACK takes priority over a pending abort
                    err_d = tx_nack ? 2'd1 : 2'd2;
                    busy_d = 1'b0; abrt_d = 1'b0; state_d = S_IDLE;
                    txs_d = 1'b0; txp_d = 1'b0;
                end else begin
                    case (state_q)
                        S_E_CTRL: state_d = S_E_REG;
                        S_E_REG:  state_d = S_E_DATA;
                        S_E_DATA: begin state_d = S_E_WAIT; timer_d = '0; end
                        S_W_CTRL: state_d = S_W_ADDR;
                        S_W_ADDR: begin
                            state_d = S_FETCH; bidx_d = 8'd0;
                            addr_d = base; clken_d = 1'b1; fph_d = 1'b0;
                        end
                        default: begin
                            if (last_byte) begin
                                state_d = S_W_WAIT; timer_d = '0;
                            end else begin
                                state_d = S_FETCH; bidx_d = bidx_q + 8'd1;
                                addr_d = base + bidx_q + 8'd1;
                                clken_d = 1'b1; fph_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end else if (abort_now) begin
            err_d = 2'd2; busy_d = 1'b0; abrt_d = 1'b0;
            clken_d = 1'b0; fph_d = 1'b0; state_d = S_IDLE;
        end else if (state_q == S_FETCH) begin
            // address is registered in the RAM: data arrives one cycle after clken
            clken_d = 1'b0;
            if (!fph_q) begin
                fph_d = 1'b1;
            end else begin
                fph_d = 1'b0; txd_d = mem_readdata; txs_d = 1'b0;
                txp_d = last_byte; txv_d = 1'b1; state_d = S_W_DATA;
            end
        end else if (timer_q != TW'(WAIT_CYCLES - 1)) begin
            timer_d = timer_q + 1'b1;
        end else if (state_q == S_E_WAIT) begin
            state_d = S_W_CTRL;
        end else if (page_q == 4'(NUM_PAGES - 1)) begin
            done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
        end else begin
            page_d = page_q + 4'd1; state_d = S_E_CTRL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE; busy_q <= 1'b0; done_q <= 1'b0;
            err_q   <= 2'd0;   page_q <= 4'd0; addr_q <= 8'd0;
            clken_q <= 1'b0;   txv_q  <= 1'b0; txd_q  <= 8'd0;
            txs_q   <= 1'b0;   txp_q  <= 1'b0; sent_q <= 1'b0;
            fph_q   <= 1'b0;   abrt_q <= 1'b0; timer_q <= '0;
            bidx_q  <= 8'd0;
        end else begin
            state_q <= state_d; busy_q <= busy_d; done_q <= done_d;
            err_q   <= err_d;   page_q <= page_d; addr_q <= addr_d;
            clken_q <= clken_d; txv_q  <= txv_d;  txd_q  <= txd_d;
            txs_q   <= txs_d;   txp_q  <= txp_d;  sent_q <= sent_d;
            fph_q   <= fph_d;   abrt_q <= abrt_d; timer_q <= timer_d;
            bidx_q  <= bidx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_code    = err_q;
    assign page_idx    = page_q;
    assign mem_address = addr_q;
    assign mem_clken   = clken_q;
    assign tx_valid    = txv_q;
    assign tx_data     = txd_q;
    assign tx_start    = txs_q;
    assign tx_stop     = txp_q;
endmodule

// File: tb/tb_nvm_page_program_sequencer.sv
// Scoreboard bench: expected I2C byte stream built from the page-program rules,
// compared against every tx handshake by an independent monitor.
module tb_nvm_page_program_sequencer;
    logic       clk = 1'b0;
    logic       reset_n, start, abort;
    logic       busy, done;
    logic [1:0] err_code;
    logic [3:0] page_idx;
    logic [7:0] mem_address, mem_readdata;
    logic       mem_clken;
    logic       tx_valid, tx_ready, tx_start, tx_stop, tx_done, tx_nack;
    logic [7:0] tx_data;

    nvm_page_program_sequencer #(.WAIT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .err_code(err_code), .page_idx(page_idx),
        .mem_address(mem_address), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_stop(tx_stop),
        .tx_done(tx_done), .tx_nack(tx_nack)
    );

    always #5 clk = ~clk;

    logic [7:0] img [256];
    always @(posedge clk)
        if (mem_clken) mem_readdata <= img[mem_address];

    int checks = 0, failures = 0;
    logic [13:0] exp_q [$];
    int dn_cnt = 0, done_cnt = 0, nack_at = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference stream: erase (3 bytes) then write (2 + PAGE_BYTES) per page.
    // Item = {data, start, stop, page}; n limits how many bytes are expected.
    task automatic push_stream(input int n);
        int k = 0;
        for (int p = 0; p < 16; p++) begin
            logic [13:0] it [$];
            it.push_back({8'h10, 1'b1, 1'b0, 4'(p)});
            it.push_back({8'hE3, 1'b0, 1'b0, 4'(p)});
            it.push_back({8'h80 + 8'(p), 1'b0, 1'b1, 4'(p)});
            it.push_back({8'h14, 1'b1, 1'b0, 4'(p)});
            it.push_back({8'(p * 16), 1'b0, 1'b0, 4'(p)});
            for (int i = 0; i < 16; i++)
                it.push_back({img[p * 16 + i], 1'b0, (i == 15), 4'(p)});
            foreach (it[j]) begin
                if (k < n) exp_q.push_back(it[j]);
                k++;
            end
        end
    endtask

    // I2C master model
    initial begin
        int mst = 0, cnt = 0;
        tx_ready = 1'b0; tx_done = 1'b0; tx_nack = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0; tx_nack = 1'b0;
            if (!reset_n) begin
                mst = 0; tx_ready = 1'b0;
            end else begin
                case (mst)
                    0: if (tx_valid) begin
                        cnt = (dn_cnt % 25 == 7) ? 10 : int'($urandom_range(0, 3));
                        mst = 1;
                    end
                    1: if (cnt == 0) begin tx_ready = 1'b1; mst = 2; end
                       else cnt--;
                    2: begin tx_ready = 1'b0; cnt = int'($urandom_range(0, 2)); mst = 3; end
                    default: if (cnt == 0) begin
                        tx_done = 1'b1; tx_nack = (dn_cnt == nack_at);
                        dn_cnt++; mst = 0;
                    end else cnt--;
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stability while stalled
    initial begin
        logic       stall = 1'b0;
        logic [9:0] held = '0;
        logic [13:0] e;
        forever begin
            @(negedge clk); #1;
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (tx_valid) begin
                    if (stall) chk("stable", {22'd0, tx_data, tx_start, tx_stop}, {22'd0, held});
                    if (tx_ready) begin
                        stall = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL extra_byte: got %0h expected none", tx_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("tx_byte", {18'd0, tx_data, tx_start, tx_stop, page_idx}, {18'd0, e});
                        end
                    end else begin
                        stall = 1'b1; held = {tx_data, tx_start, tx_stop};
                    end
                end else stall = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20000) begin step(); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 256; i++) img[i] = 8'(i);
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, err_code, page_idx, mem_clken, tx_valid, tx_start, tx_stop},
            0);
        chk("rst_addr_data", {mem_address, tx_data}, 0);
        reset_n = 1'b1; step();

        // 1/4/6: full image, start re-pulsed mid-run at page 1, stretched ready
        dn_cnt = 0; done_cnt = 0;
        push_stream(1000);
        pulse_start();
        chk("busy_after_start", busy, 1);
        n = 0;
        while (page_idx != 4'd1 && n < 5000) begin step(); n++; end
        chk("reach_page1", page_idx, 1);
        pulse_start();
        wait_idle("full");
        chk("full_done", done_cnt, 1);
        chk("full_err", err_code, 0);
        chk("full_bytes", dn_cnt, 336);
        chk("full_q_empty", exp_q.size(), 0);

        // 2: NACK on 5th data byte of page 3
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        dn_cnt = 0; done_cnt = 0; nack_at = 3 * 21 + 5 + 4;
        push_stream(nack_at + 1);
        pulse_start();
        wait_idle("nack");
        nack_at = -1;
        chk("nack_err", err_code, 1);
        chk("nack_no_done", done_cnt, 0);
        n = 0;
        repeat (30) begin step(); if (tx_valid) n++; end
        chk("nack_silent", n, 0);
        chk("nack_q_empty", exp_q.size(), 0);

        // 3a: abort during W_WAIT of page 0
        dn_cnt = 0; done_cnt = 0;
        push_stream(21);
        pulse_start();
        chk("err_cleared", err_code, 0);
        n = 0;
        while (dn_cnt < 21 && n < 2000) begin step(); n++; end
        step(); step();
        chk("wwait_busy", busy, 1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("wwait_abort_err", err_code, 2);
        chk("wwait_abort_busy", busy, 0);
        chk("wwait_q_empty", exp_q.size(), 0);

        // 3b: abort during a W_DATA byte, honoured only after its tx_done
        dn_cnt = 0; done_cnt = 0;
        push_stream(9);
        pulse_start();
        n = 0;
        while (!(dn_cnt == 8 && tx_valid && tx_ready) && n < 2000) begin step(); n++; end
        abort = 1'b1; step(); abort = 1'b0;
        chk("wdata_abort_pending", {busy, err_code}, {1'b1, 2'd0});
        wait_idle("wdata_abort");
        chk("wdata_abort_err", err_code, 2);
        chk("wdata_abort_bytes", dn_cnt, 9);
        repeat (10) step();
        chk("wdata_q_empty", exp_q.size(), 0);

        // 5: async reset while a page-7 data byte is pending
        dn_cnt = 0; done_cnt = 0;
        push_stream(1000);
        pulse_start();
        n = 0;
        while (!(page_idx == 4'd7 && tx_valid && !tx_ready && dn_cnt >= 7 * 21 + 5)
               && n < 10000) begin step(); n++; end
        chk("reach_page7_data", {page_idx, tx_valid}, {4'd7, 1'b1});
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy_txv_clken", {busy, tx_valid, mem_clken}, 0);
        chk("async_rst_page_err", {page_idx, err_code}, 0);
        exp_q.delete();
        repeat (3) step();
        reset_n = 1'b1; step();
        dn_cnt = 0; done_cnt = 0;
        push_stream(1000);
        pulse_start();
        chk("restart_page", page_idx, 0);
        wait_idle("restart");
        chk("restart_done", done_cnt, 1);
        chk("restart_err", err_code, 0);
        chk("restart_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
